// File: rtl/mat_pkg.sv
// Shared constants and state encoding for the 2x2 matrix datapath
// (operand loader, multiplier and later stages).
package mat_pkg;
    localparam int unsigned ELEM_W    = 8;
    localparam int unsigned N         = 2;
    localparam int unsigned MAT_W     = N * N * ELEM_W;
    localparam int unsigned FRAME_LEN = 2 * N * N;
    localparam int unsigned IDX_W     = $clog2(FRAME_LEN);
    localparam int unsigned OPS_W     = 2 * MAT_W;
    localparam int unsigned ERR_CNT_W = 8;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        HOLD = 2'd1,
        SYNC = 2'd2
    } state_e;
endpackage

// File: rtl/mat_pack_reg.sv
// 64-bit operand register with a byte-addressed write port.
// Slot 0 is the MSB byte (A00), slot FRAME_LEN-1 the LSB byte (B11).
module mat_pack_reg
    import mat_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [ELEM_W-1:0] i_data,
    output logic [OPS_W-1:0]  o_ops
);
    logic [OPS_W-1:0] r_ops;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ops <= '0;
        end else if (i_we) begin
            for (int unsigned s = 0; s < FRAME_LEN; s++) begin
                if (i_idx == IDX_W'(s)) begin
                    r_ops[OPS_W-1-ELEM_W*s -: ELEM_W] <= i_data;
                end
            end
        end
    end

    assign o_ops = r_ops;
endmodule

// File: rtl/mat_operand_loader.sv
// Byte-serial frame loader feeding packed A/B operands to the 2x2 multiplier,
// with framing-error detection and a saturating error counter.
module mat_operand_loader
    import mat_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ELEM_W-1:0]    in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [MAT_W-1:0]     out_a,
    output logic [MAT_W-1:0]     out_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    state_e               r_state;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    state_e               w_state_nxt;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic                 w_err_nxt;
    logic                 w_we;
    logic                 w_xfer;
    logic                 w_last_slot;
    logic [OPS_W-1:0]     w_ops;

    assign w_xfer      = in_valid & r_in_ready;
    assign w_last_slot = (r_idx == IDX_W'(FRAME_LEN - 1));

    // Next-state, index and error decode
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_err_nxt   = 1'b0;
        w_we        = 1'b0;
        case (r_state)
            LOAD: begin
                if (w_xfer) begin
                    w_we = 1'b1;
                    if (w_last_slot) begin
                        w_idx_nxt = '0;
                        if (in_last) begin
                            w_state_nxt = HOLD;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = SYNC;
                        end
                    end else if (in_last) begin
                        w_err_nxt = 1'b1;
                        w_idx_nxt = '0;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_nxt = LOAD;
                end
            end
            SYNC: begin
                // Drop bytes until the producer's end-of-frame realigns us
                if (w_xfer && in_last) begin
                    w_state_nxt = LOAD;
                    w_idx_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = LOAD;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Handshake flags are registered from the next state so neither
    // in_ready nor out_valid depends combinationally on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= LOAD;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_in_ready  <= (w_state_nxt != HOLD);
            r_out_valid <= (w_state_nxt == HOLD);
            r_err       <= w_err_nxt;
            if (w_err_nxt && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
        end
    end

    mat_pack_reg u_pack (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (w_we),
        .i_idx  (r_idx),
        .i_data (in_data),
        .o_ops  (w_ops)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign err       = r_err;
    assign err_cnt   = r_err_cnt;
    assign out_a     = w_ops[OPS_W-1:MAT_W];
    assign out_b     = w_ops[MAT_W-1:0];
endmodule

// File: tb/tb_mat_operand_loader.sv
// Directed self-checking bench for mat_operand_loader.
module tb_mat_operand_loader;
    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic        out_valid;
    logic        out_ready;
    logic        err;
    logic [7:0]  err_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] exp_cnt = 8'd0;

    mat_operand_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transfer; returns #1 after the edge that accepted the byte.
    task automatic send(input logic [7:0] d, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] first);
        for (int i = 0; i < 8; i++) send(first + 8'(i), (i == 7));
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_chk++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_chk++; if (out_a !== 32'h0 || out_b !== 32'h0) begin n_fail++; $display("FAIL rst_ops: got %h/%h want 0/0", out_a, out_b); end
        n_chk++; if (err !== 1'b0 || err_cnt !== 8'h00) begin n_fail++; $display("FAIL rst_err: got %b/%h want 0/00", err, err_cnt); end
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        send_frame(8'h01);
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        n_chk++; if (out_a !== 32'h01020304) begin n_fail++; $display("FAIL basic_a: got %h want 01020304", out_a); end
        n_chk++; if (out_b !== 32'h05060708) begin n_fail++; $display("FAIL basic_b: got %h want 05060708", out_b); end
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_hold: got %b want 0", in_ready); end
        @(posedge clk); #1;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_1cyc: got %b want 0", out_valid); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_back: got %b want 1", in_ready); end
    endtask

    task automatic test_hold;
        out_ready = 1'b0;
        send_frame(8'h21);
        // Junk offered during HOLD must not be taken
        in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            n_chk++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_a !== 32'h21222324 || out_b !== 32'h25262728) begin
                n_fail++;
                $display("FAIL hold_c%0d: v=%b rdy=%b a=%h b=%h want 1 0 21222324 25262728", c, out_valid, in_ready, out_a, out_b);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release: v=%b rdy=%b want 0 1", out_valid, in_ready); end
        n_chk++; if (err !== 1'b0 || err_cnt !== exp_cnt) begin n_fail++; $display("FAIL hold_noerr: err=%b cnt=%h want 0 %h", err, err_cnt, exp_cnt); end
    endtask

    task automatic test_short;
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        send(8'hA3, 1'b1);
        exp_cnt = exp_cnt + 8'd1;
        n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL short_err: got %b want 1", err); end
        n_chk++; if (err_cnt !== exp_cnt) begin n_fail++; $display("FAIL short_cnt: got %h want %h", err_cnt, exp_cnt); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL short_valid: got %b want 0", out_valid); end
        @(posedge clk); #1;
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL short_err_pulse: got %b want 0", err); end
        send_frame(8'h09);
        n_chk++; if (out_valid !== 1'b1 || out_a !== 32'h090A0B0C || out_b !== 32'h0D0E0F10) begin
            n_fail++; $display("FAIL short_next: v=%b a=%h b=%h want 1 090A0B0C 0D0E0F10", out_valid, out_a, out_b);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_long;
        int errs;
        errs = 0;
        for (int i = 0; i < 11; i++) begin
            send(8'h30 + 8'(i), (i == 10));
            if (err === 1'b1) errs++;
            n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL long_valid_b%0d: got %b want 0", i, out_valid); end
        end
        exp_cnt = exp_cnt + 8'd1;
        n_chk++; if (errs != 1) begin n_fail++; $display("FAIL long_err_pulses: got %0d want 1", errs); end
        n_chk++; if (err_cnt !== exp_cnt) begin n_fail++; $display("FAIL long_cnt: got %h want %h", err_cnt, exp_cnt); end
        send_frame(8'h41);
        n_chk++; if (out_valid !== 1'b1 || out_a !== 32'h41424344 || out_b !== 32'h45464748) begin
            n_fail++; $display("FAIL long_next: v=%b a=%h b=%h want 1 41424344 45464748", out_valid, out_a, out_b);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_midreset;
        for (int i = 0; i < 5; i++) send(8'h51 + 8'(i), 1'b0);
        rst_n = 1'b0; #2;
        n_chk++; if (out_valid !== 1'b0 || out_a !== 32'h0 || out_b !== 32'h0 || in_ready !== 1'b1 || err_cnt !== 8'h00) begin
            n_fail++; $display("FAIL rst_mid: v=%b a=%h b=%h rdy=%b cnt=%h want 0 0 0 1 00", out_valid, out_a, out_b, in_ready, err_cnt);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        exp_cnt = 8'd0;
        out_ready = 1'b0;
        send_frame(8'h61);
        rst_n = 1'b0; #2;
        n_chk++; if (out_valid !== 1'b0 || out_a !== 32'h0 || out_b !== 32'h0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_hold: v=%b a=%h b=%h rdy=%b want 0 0 0 1", out_valid, out_a, out_b, in_ready);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        out_ready = 1'b1;
        send_frame(8'h71);
        n_chk++; if (out_valid !== 1'b1 || out_a !== 32'h71727374 || out_b !== 32'h75767778 || err_cnt !== 8'h00) begin
            n_fail++; $display("FAIL rst_clean: v=%b a=%h b=%h cnt=%h want 1 71727374 75767778 00", out_valid, out_a, out_b, err_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_saturate;
        for (int f = 0; f < 256; f++) begin
            send(8'(f), 1'b1);
            if (f == 254) begin
                n_chk++; if (err_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_255: got %h want FF", err_cnt); end
            end
        end
        n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL sat_err: got %b want 1", err); end
        n_chk++; if (err_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_cnt: got %h want FF", err_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_short();
        test_long();
        test_midreset();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
